// File: rtl/cordic_lut_loader_if.sv
// Valid/ready stream carrying 16-bit table half-words into the loader.
interface cordic_lut_loader_if #(
    parameter int IW = 16
);
    logic [IW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/cordic_lut_loader.sv
// Assembles 48-bit CORDIC table entries from a half-word stream, writes them
// into the core table and holds the core in reset until the table is full.
module cordic_lut_loader #(
    parameter int ENTRIES    = 64,
    parameter int AW         = 6,
    parameter int DW         = 48,
    parameter int IW         = 16,
    parameter int CLR_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    cordic_lut_loader_if.slave  s,
    output logic                wen,
    output logic [AW-1:0]       index_wri,
    output logic [DW-1:0]       D,
    output logic                core_reset_n,
    output logic                busy,
    output logic                done
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CLEAR,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    half;
    logic [AW-1:0] idx;
    logic [CW-1:0] clr;
    logic [DW-1:0] asm_q;
    logic [DW-1:0] asm_nx;
    logic          accept;
    logic          last_half;
    logic          last_idx;
    logic          clr_end;
    logic          restart;

    assign accept    = (state == COLLECT) && s.s_valid;
    assign last_half = (half == 2'd2);
    assign last_idx  = (idx == AW'(ENTRIES - 1));
    assign clr_end   = (clr == CW'(CLR_CYCLES - 1));
    assign restart   = ((state == IDLE) || (state == RUN)) && start;
    assign asm_nx    = {asm_q[DW-IW-1:0], s.s_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        s.s_ready    = 1'b0;
        wen          = 1'b1;
        core_reset_n = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = COLLECT;
            end
            COLLECT: begin
                s.s_ready = 1'b1;
                busy      = 1'b1;
                if (accept && last_half) state_nx = WRITE;
            end
            WRITE: begin
                wen      = 1'b0;
                busy     = 1'b1;
                state_nx = last_idx ? CLEAR : COLLECT;
            end
            CLEAR: begin
                busy = 1'b1;
                if (clr_end) state_nx = RUN;
            end
            RUN: begin
                core_reset_n = 1'b1;
                done         = 1'b1;
                if (start) state_nx = COLLECT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The write port is loaded on the third accept so D is stable for the
    // whole WRITE cycle and simply holds afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half      <= '0;
            idx       <= '0;
            clr       <= '0;
            asm_q     <= '0;
            index_wri <= '0;
            D         <= '0;
        end else begin
            if (restart) begin
                half <= '0;
                idx  <= '0;
                clr  <= '0;
            end
            if (accept) begin
                asm_q <= asm_nx;
                if (last_half) begin
                    half      <= '0;
                    D         <= asm_nx;
                    index_wri <= idx;
                end else begin
                    half <= half + 2'd1;
                end
            end
            if ((state == WRITE) && !last_idx) begin
                idx <= idx + AW'(1);
            end
            if (state == CLEAR) begin
                clr <= clr_end ? '0 : clr + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cordic_lut_loader.sv
// Randomized bench for cordic_lut_loader with a stream-level model of
// accepted halves, expected table writes and core release timing.
module tb_cordic_lut_loader;

    localparam int ENTRIES = 64;
    localparam int AW      = 6;
    localparam int DW      = 48;
    localparam int IW      = 16;
    localparam int CLR     = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          wen;
    logic [AW-1:0] index_wri;
    logic [DW-1:0] D;
    logic          core_reset_n;
    logic          busy;
    logic          done;

    cordic_lut_loader_if #(.IW(IW)) bus ();

    cordic_lut_loader #(
        .ENTRIES    (ENTRIES),
        .AW         (AW),
        .DW         (DW),
        .IW         (IW),
        .CLR_CYCLES (CLR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .s            (bus),
        .wen          (wen),
        .index_wri    (index_wri),
        .D            (D),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_tab [ENTRIES];
    int  cyc      = 0;
    int  halves   = 0;
    int  wcount   = 0;
    int  lw_cyc   = 0;
    bit  pend     = 1'b0;
    bit  lw_valid = 1'b0;

    // Reference model: counts accepted halves; every third accept must be
    // followed by exactly one write cycle carrying the next table entry.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            halves   = 0;
            wcount   = 0;
            pend     = 1'b0;
            lw_valid = 1'b0;
        end else begin
            if (pend) begin
                chk("wr_wen", 64'(wen), 64'd0);
                chk("wr_ready", 64'(bus.s_ready), 64'd0);
                chk("wr_idx", 64'(index_wri), 64'(wcount));
                if (wcount < ENTRIES)
                    chk("wr_data", 64'(D), 64'(exp_tab[wcount]));
                else
                    chk("wr_extra", 64'(wcount), 64'(ENTRIES - 1));
                wcount++;
                pend = 1'b0;
                if (wcount == ENTRIES) begin
                    lw_valid = 1'b1;
                    lw_cyc   = cyc;
                end
            end else begin
                chk("wen_idle", 64'(wen), 64'd1);
            end
            if (lw_valid) begin
                if (cyc - lw_cyc <= CLR) begin
                    chk("clr_crn", 64'(core_reset_n), 64'd0);
                    chk("clr_done", 64'(done), 64'd0);
                    chk("clr_busy", 64'(busy), 64'd1);
                end else begin
                    chk("rel_crn", 64'(core_reset_n), 64'd1);
                    chk("rel_done", 64'(done), 64'd1);
                    chk("rel_busy", 64'(busy), 64'd0);
                    lw_valid = 1'b0;
                end
            end
            if (start && !busy) begin
                halves = 0;
                wcount = 0;
            end else if (bus.s_valid && bus.s_ready) begin
                halves++;
                if (halves == 3) begin
                    halves = 0;
                    pend   = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_half(input logic [IW-1:0] w, input int gap);
        int n;
        repeat (gap) begin
            tick();
            bus.s_valid = 1'b0;
        end
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        n = 0;
        while (!bus.s_ready && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("ready_timeout", 64'(bus.s_ready), 64'd1);
    endtask

    task automatic load(input int maxgap, input bit rnd, input bit poke,
                        input int n_ent, input int extra);
        logic [IW-1:0] w [3];
        for (int k = 0; k < n_ent; k++) begin
            for (int h = 0; h < 3; h++) begin
                if (rnd) w[h] = IW'($urandom);
                else     w[h] = {8'(k), 4'h0, 4'(4'hA + h)};
            end
            exp_tab[k] = {w[0], w[1], w[2]};
            for (int h = 0; h < 3; h++) begin
                if (poke && k == 10 && h == 1) begin
                    tick();
                    bus.s_valid = 1'b0;
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                send_half(w[h], int'($urandom_range(maxgap, 0)));
            end
        end
        for (int e = 0; e < extra; e++) send_half(IW'($urandom), 0);
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ready", 64'(bus.s_ready), 64'd1);
        chk("start_crn", 64'(core_reset_n), 64'd0);
        chk("start_done", 64'(done), 64'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 5000) begin
            tick();
            n++;
        end
        chk("done_wait", 64'(done), 64'd1);
        tick();
        chk("wr_count", 64'(wcount), 64'(ENTRIES));
        chk("run_crn", 64'(core_reset_n), 64'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wen"}, 64'(wen), 64'd1);
        chk({tag, "_idx"}, 64'(index_wri), 64'd0);
        chk({tag, "_d"}, 64'(D), 64'd0);
        chk({tag, "_crn"}, 64'(core_reset_n), 64'd0);
        chk({tag, "_ready"}, 64'(bus.s_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) tick();
        chk_reset_outs("rst");
        reset = 1'b0;
        repeat (2) tick();
        chk("idle_crn", 64'(core_reset_n), 64'd0);
        chk("idle_ready", 64'(bus.s_ready), 64'd0);

        do_start();
        load(0, 1'b0, 1'b0, ENTRIES, 0);
        wait_done();

        do_start();
        load(5, 1'b1, 1'b1, ENTRIES, 0);
        wait_done();

        do_start();
        load(3, 1'b1, 1'b0, 21, 1);
        tick();
        reset = 1'b1;
        #1;
        chk_reset_outs("mid");
        tick();
        reset = 1'b0;
        tick();
        chk("mid_idle_crn", 64'(core_reset_n), 64'd0);

        do_start();
        load(5, 1'b1, 1'b0, ENTRIES, 0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
